// File: rtl/bp_be_issue_sequencer.sv
`default_nettype none
// bp_be_issue_sequencer: issue-queue control sequencer (en/clr/roll/read/cmt) with an in-flight bound.
// Optional statistics counters are built when BP_BE_ISSUE_SEQUENCER_STATS_EN is defined.
module bp_be_issue_sequencer #(
  parameter int fetch_cinstr_p = 2,
  parameter int inflight_max_p = 8,
  localparam int ptr_w = $clog2(fetch_cinstr_p+1),
  localparam int ifl_w = $clog2(inflight_max_p+1)
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             issue_v_i,
  input  logic [ptr_w-1:0] issue_size_i,
  input  logic [ptr_w-1:0] issue_count_i,
  input  logic             dispatch_ready_i,
  output logic             dispatch_v_o,
  input  logic             commit_v_i,
  input  logic [ptr_w-1:0] commit_size_i,
  input  logic [ptr_w-1:0] commit_count_i,
  input  logic             roll_i,
  input  logic             flush_i,
  input  logic             halt_i,
  output logic             en_o,
  output logic             clr_o,
  output logic             roll_o,
  output logic             read_o,
  output logic             cmt_o,
  output logic [ptr_w-1:0] read_size_o,
  output logic [ptr_w-1:0] read_cnt_o,
  output logic [ptr_w-1:0] cmt_size_o,
  output logic [ptr_w-1:0] cmt_cnt_o,
  output logic [ifl_w-1:0] inflight_o,
  output logic [2:0]       state_o,
  output logic [31:0]      stall_cnt_o,
  output logic [31:0]      roll_cnt_o
);

  typedef enum logic [2:0] {
    e_init  = 3'd0,
    e_run   = 3'd1,
    e_roll  = 3'd2,
    e_clear = 3'd3,
    e_halt  = 3'd4
  } state_e;

  localparam logic [ifl_w-1:0] c_ifl_max = ifl_w'(inflight_max_p);
  localparam logic [ifl_w-1:0] c_ifl_one = ifl_w'(1);

  state_e           state_q, state_d;
  logic [ifl_w-1:0] inflight_q, inflight_d;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= e_init;
      inflight_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
    end
  end

  // Flush outranks everything, so a held flush keeps the queue in e_clear.
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_init:  state_d = e_clear;
      e_clear: begin
        if (flush_i)     state_d = e_clear;
        else if (halt_i) state_d = e_halt;
        else             state_d = e_run;
      end
      e_run, e_halt: begin
        if (flush_i)     state_d = e_clear;
        else if (roll_i) state_d = e_roll;
        else if (halt_i) state_d = e_halt;
        else             state_d = e_run;
      end
      e_roll: begin
        if (flush_i) state_d = e_clear;
        else         state_d = e_run;
      end
      default: state_d = e_init;
    endcase
  end

  assign en_o   = (state_q == e_run);
  assign clr_o  = (state_q == e_clear);
  assign roll_o = (state_q == e_roll);

  assign dispatch_v_o = (state_q == e_run) & issue_v_i & (inflight_q < c_ifl_max)
                        & ~roll_i & ~flush_i;
  assign read_o       = dispatch_v_o & dispatch_ready_i;
  assign read_size_o  = issue_size_i;
  assign read_cnt_o   = issue_count_i;

  // Commits stay live during a roll; the queue folds the dequeue into the replay.
  assign cmt_o      = commit_v_i & (state_q != e_init) & (state_q != e_clear);
  assign cmt_size_o = commit_size_i;
  assign cmt_cnt_o  = commit_count_i;

  always_comb begin
    inflight_d = inflight_q;
    if ((state_q == e_roll) || (state_q == e_clear)) begin
      inflight_d = '0;
    end else if (read_o && !cmt_o) begin
      inflight_d = inflight_q + c_ifl_one;
    end else if (cmt_o && !read_o && (inflight_q != '0)) begin
      inflight_d = inflight_q - c_ifl_one;
    end
  end

  assign inflight_o = inflight_q;
  assign state_o    = state_q;

  a_no_underflow: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    !(cmt_o && (inflight_q == '0)));

`ifdef BP_BE_ISSUE_SEQUENCER_STATS_EN
  logic [31:0] stall_cnt_q, roll_cnt_q;
  logic        stall_ev, roll_ev;

  assign stall_ev = (state_q == e_run) & issue_v_i & ~dispatch_v_o;
  assign roll_ev  = (state_d == e_roll) & (state_q != e_roll);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      stall_cnt_q <= '0;
      roll_cnt_q  <= '0;
    end else begin
      if (stall_ev && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (roll_ev && (roll_cnt_q != '1))   roll_cnt_q  <= roll_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign roll_cnt_o  = roll_cnt_q;
`else
  assign stall_cnt_o = '0;
  assign roll_cnt_o  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bp_be_issue_sequencer.sv
`default_nettype none
// tb_bp_be_issue_sequencer: directed self-checking bench for bp_be_issue_sequencer.
module tb_bp_be_issue_sequencer;

  localparam int ptr_w = 2;
  localparam int ifl_w = 4;

`ifdef BP_BE_ISSUE_SEQUENCER_STATS_EN
  localparam bit c_stats_en = 1'b1;
`else
  localparam bit c_stats_en = 1'b0;
`endif

  logic             clk_i = 1'b0;
  logic             reset_n_i;
  logic             issue_v_i, dispatch_ready_i, dispatch_v_o;
  logic [ptr_w-1:0] issue_size_i, issue_count_i;
  logic             commit_v_i;
  logic [ptr_w-1:0] commit_size_i, commit_count_i;
  logic             roll_i, flush_i, halt_i;
  logic             en_o, clr_o, roll_o, read_o, cmt_o;
  logic [ptr_w-1:0] read_size_o, read_cnt_o, cmt_size_o, cmt_cnt_o;
  logic [ifl_w-1:0] inflight_o;
  logic [2:0]       state_o;
  logic [31:0]      stall_cnt_o, roll_cnt_o;

  int n_tests = 0;
  int n_fail  = 0;

  bp_be_issue_sequencer #(.fetch_cinstr_p(2), .inflight_max_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .issue_v_i(issue_v_i), .issue_size_i(issue_size_i), .issue_count_i(issue_count_i),
    .dispatch_ready_i(dispatch_ready_i), .dispatch_v_o(dispatch_v_o),
    .commit_v_i(commit_v_i), .commit_size_i(commit_size_i), .commit_count_i(commit_count_i),
    .roll_i(roll_i), .flush_i(flush_i), .halt_i(halt_i),
    .en_o(en_o), .clr_o(clr_o), .roll_o(roll_o), .read_o(read_o), .cmt_o(cmt_o),
    .read_size_o(read_size_o), .read_cnt_o(read_cnt_o),
    .cmt_size_o(cmt_size_o), .cmt_cnt_o(cmt_cnt_o),
    .inflight_o(inflight_o), .state_o(state_o),
    .stall_cnt_o(stall_cnt_o), .roll_cnt_o(roll_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n_i = 1'b0;
    issue_v_i = 1'b0; dispatch_ready_i = 1'b0;
    issue_size_i = '0; issue_count_i = '0;
    commit_v_i = 1'b0; commit_size_i = '0; commit_count_i = '0;
    roll_i = 1'b0; flush_i = 1'b0; halt_i = 1'b0;

    tick(); tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_inflight", 32'(inflight_o), 32'd0);
    check("rst_ctl", {27'd0, en_o, clr_o, roll_o, read_o, cmt_o}, 32'd0);
    check("rst_dispatch", 32'(dispatch_v_o), 32'd0);
    check("rst_stall", stall_cnt_o, 32'd0);
    check("rst_rollcnt", roll_cnt_o, 32'd0);

    // Reset release: init, clear, run
    reset_n_i = 1'b1;
    #1;
    check("c1_init", 32'(state_o), 32'd0);
    tick();
    check("c2_clr", 32'(clr_o), 32'd1);
    check("c2_state", 32'(state_o), 32'd3);
    tick();
    check("c3_state", 32'(state_o), 32'd1);
    check("c3_en", 32'(en_o), 32'd1);

    // Fill to the in-flight limit
    issue_v_i = 1'b1; dispatch_ready_i = 1'b1;
    issue_size_i = 2'd1; issue_count_i = 2'd2;
    commit_size_i = 2'd2; commit_count_i = 2'd2;
    #1;
    for (int i = 0; i < 8; i++) begin
      check("fill_read", 32'(read_o), 32'd1);
      check("fill_ifl", 32'(inflight_o), 32'(i));
      tick();
    end
    check("full_ifl", 32'(inflight_o), 32'd8);
    check("full_dispatch", 32'(dispatch_v_o), 32'd0);
    check("full_read", 32'(read_o), 32'd0);
    commit_v_i = 1'b1;
    #1;
    check("full_cmt", 32'(cmt_o), 32'd1);
    check("full_cmt_read", 32'(read_o), 32'd0);
    tick();
    commit_v_i = 1'b0;
    #1;
    check("resume_ifl", 32'(inflight_o), 32'd7);
    check("resume_read", 32'(read_o), 32'd1);
    tick();
    check("refill_ifl", 32'(inflight_o), 32'd8);

    // Drain to 3
    issue_v_i = 1'b0; commit_v_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    commit_v_i = 1'b0;
    #1;
    check("drain_ifl", 32'(inflight_o), 32'd3);

    // Simultaneous read and commit, operands pass through
    issue_v_i = 1'b1; commit_v_i = 1'b1;
    issue_size_i = 2'd1; issue_count_i = 2'd2;
    commit_size_i = 2'd2; commit_count_i = 2'd1;
    #1;
    check("both_read", 32'(read_o), 32'd1);
    check("both_cmt", 32'(cmt_o), 32'd1);
    check("read_size", 32'(read_size_o), 32'd1);
    check("read_cnt", 32'(read_cnt_o), 32'd2);
    check("cmt_size", 32'(cmt_size_o), 32'd2);
    check("cmt_cnt", 32'(cmt_cnt_o), 32'd1);
    tick();
    check("both_ifl", 32'(inflight_o), 32'd3);

    // Build to 5 then roll with commit held
    commit_v_i = 1'b0;
    tick(); tick();
    issue_v_i = 1'b0;
    #1;
    check("pre_roll_ifl", 32'(inflight_o), 32'd5);
    roll_i = 1'b1; commit_v_i = 1'b1; issue_v_i = 1'b1;
    #1;
    check("roll_req_disp", 32'(dispatch_v_o), 32'd0);
    check("roll_req_cmt", 32'(cmt_o), 32'd1);
    tick();
    roll_i = 1'b0;
    #1;
    check("roll_state", 32'(state_o), 32'd2);
    check("roll_o", 32'(roll_o), 32'd1);
    check("roll_cmt", 32'(cmt_o), 32'd1);
    check("roll_en", 32'(en_o), 32'd0);
    check("roll_ifl", 32'(inflight_o), 32'd4);
    tick();
    commit_v_i = 1'b0; issue_v_i = 1'b0;
    #1;
    check("post_roll_state", 32'(state_o), 32'd1);
    check("post_roll_ifl", 32'(inflight_o), 32'd0);

    // Flush beats roll; held flush keeps clearing; then halt
    flush_i = 1'b1; roll_i = 1'b1;
    tick();
    check("fl_state", 32'(state_o), 32'd3);
    check("fl_clr", 32'(clr_o), 32'd1);
    check("fl_roll", 32'(roll_o), 32'd0);
    tick();
    check("fl_hold_clr", 32'(clr_o), 32'd1);
    flush_i = 1'b0; roll_i = 1'b0; halt_i = 1'b1; issue_v_i = 1'b1;
    tick();
    check("halt_state", 32'(state_o), 32'd4);
    check("halt_en", 32'(en_o), 32'd0);
    check("halt_disp", 32'(dispatch_v_o), 32'd0);
    check("halt_clr", 32'(clr_o), 32'd0);
    halt_i = 1'b0; issue_v_i = 1'b0;
    tick();
    check("unhalt_state", 32'(state_o), 32'd1);
    check("unhalt_en", 32'(en_o), 32'd1);

    // Reset asserted mid-roll aborts immediately
    roll_i = 1'b1;
    tick();
    roll_i = 1'b0;
    check("mid_roll", 32'(roll_o), 32'd1);
    reset_n_i = 1'b0;
    #1;
    check("abort_state", 32'(state_o), 32'd0);
    check("abort_roll", 32'(roll_o), 32'd0);
    tick();
    reset_n_i = 1'b1;
    #1;
    check("rst2_init", 32'(state_o), 32'd0);
    tick();
    check("rst2_clr", 32'(clr_o), 32'd1);
    tick();
    check("rst2_run", 32'(state_o), 32'd1);

    // Statistics: 10 back-pressured cycles, then two rolls
    issue_v_i = 1'b1; dispatch_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("st_full_ifl", 32'(inflight_o), 32'd8);
    for (int i = 0; i < 10; i++) tick();
    check("stall_cnt", stall_cnt_o, c_stats_en ? 32'd10 : 32'd0);
    issue_v_i = 1'b0;
    for (int r = 0; r < 2; r++) begin
      roll_i = 1'b1;
      tick();
      roll_i = 1'b0;
      tick();
    end
    check("roll_cnt", roll_cnt_o, c_stats_en ? 32'd2 : 32'd0);
    check("stall_hold", stall_cnt_o, c_stats_en ? 32'd10 : 32'd0);
    check("st_end_state", 32'(state_o), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
